round_robin_arbiter_4: RTL and testbench

Four-requester round-robin arbiter with a grant/done handshake and a bounded hold time. It sits directly upstream of the 2-to-4 decoder: `gnt_idx` drives the decoder's `in` and `gnt_valid` drives its `ena`, so the decoder output is the one-hot grant vector. Fairness comes from a rotating priority pointer. A per-grant cycle counter forces release of a requester that holds the grant too long.

---
 rtl/round_robin_arbiter_4.sv | 101 ++++++++++
 tb/tb_round_robin_arbiter_4.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/round_robin_arbiter_4.sv
// Four-requester round-robin arbiter with done/withdraw release and a bounded hold time.
// gnt_idx/gnt_valid feed a 2-to-4 decoder that produces the one-hot grant.
module round_robin_arbiter_4 #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       done,
   output logic [1:0] gnt_idx,
   output logic       gnt_valid,
   output logic       timeout
);

   localparam int unsigned CntW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int unsigned TimeoutM1 = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic [CntW-1:0] CntMax = TimeoutM1[CntW-1:0];

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e          state_q, state_d;
   logic [1:0]      gnt_idx_q, gnt_idx_d;
   logic            gnt_valid_q, gnt_valid_d;
   logic            timeout_q, timeout_d;
   logic [1:0]      last_q, last_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   logic [1:0] pick_idx;
   logic       at_limit;
   logic       rel_done;
   logic       rel_wd;

   // Walk downward so the lowest offset from last+1 wins; offset 4 wraps to last itself.
   always_comb begin
      pick_idx = gnt_idx_q;
      for (int k = 4; k >= 1; k--) begin
         if (req[last_q + 2'(k)]) begin
            pick_idx = last_q + 2'(k);
         end
      end
   end

   assign at_limit = (TIMEOUT != 0) && (cnt_q == CntMax);
   assign rel_done = done;
   assign rel_wd   = !req[gnt_idx_q];

   always_comb begin
      state_d     = state_q;
      gnt_idx_d   = gnt_idx_q;
      gnt_valid_d = gnt_valid_q;
      timeout_d   = 1'b0;
      last_d      = last_q;
      cnt_d       = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (req != 4'b0000) begin
               gnt_idx_d   = pick_idx;
               gnt_valid_d = 1'b1;
               cnt_d       = '0;
               state_d     = StGrant;
            end
         end
         StGrant: begin
            if (cnt_q != {CntW{1'b1}}) begin
               cnt_d = cnt_q + 1'b1;
            end
            if (rel_done || rel_wd || at_limit) begin
               gnt_valid_d = 1'b0;
               last_d      = gnt_idx_q;
               state_d     = StIdle;
               // A done or withdrawal on the limit edge counts as a normal release.
               timeout_d   = at_limit && !rel_done && !rel_wd;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= StIdle;
         gnt_idx_q   <= 2'd0;
         gnt_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
         last_q      <= 2'b11;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         gnt_idx_q   <= gnt_idx_d;
         gnt_valid_q <= gnt_valid_d;
         timeout_q   <= timeout_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
      end
   end

   assign gnt_idx   = gnt_idx_q;
   assign gnt_valid = gnt_valid_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_round_robin_arbiter_4.sv
// Directed bench for round_robin_arbiter_4: TIMEOUT=4 main instance, plus TIMEOUT=0 and 16.
module tb_round_robin_arbiter_4;

   logic       clk;
   logic       rst;
   logic [3:0] req4, req0, req16;
   logic       done4, done0, done16;
   logic [1:0] idx4, idx0, idx16;
   logic       gv4, gv0, gv16;
   logic       to4, to0, to16;

   int n_tests;
   int n_fail;

   round_robin_arbiter_4 #(.TIMEOUT(4)) dut4 (
      .clk(clk), .rst(rst), .req(req4), .done(done4),
      .gnt_idx(idx4), .gnt_valid(gv4), .timeout(to4)
   );

   round_robin_arbiter_4 #(.TIMEOUT(0)) dut0 (
      .clk(clk), .rst(rst), .req(req0), .done(done0),
      .gnt_idx(idx0), .gnt_valid(gv0), .timeout(to0)
   );

   round_robin_arbiter_4 dut16 (
      .clk(clk), .rst(rst), .req(req16), .done(done16),
      .gnt_idx(idx16), .gnt_valid(gv16), .timeout(to16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst    = 1'b0;
      req4   = 4'b0000;
      req0   = 4'b0000;
      req16  = 4'b0000;
      done4  = 1'b0;
      done0  = 1'b0;
      done16 = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset;
      do_reset();
      req4 = 4'b1111;
      rst  = 1'b0;
      tick();
      tick();
      n_tests++;
      if (gv4 !== 1'b0 || idx4 !== 2'd0 || to4 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: got valid=%b idx=%0d to=%b, want 0/0/0", gv4, idx4, to4);
      end
      rst = 1'b1;
      tick();
      n_tests++;
      if (gv4 !== 1'b1 || idx4 !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_first_grant: got valid=%b idx=%0d, want 1/0", gv4, idx4);
      end
   endtask

   task automatic test_rotation;
      logic [1:0] exp_seq [5];
      exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      do_reset();
      req4 = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_tests++;
         if (gv4 !== 1'b1 || idx4 !== exp_seq[i]) begin
            n_fail++;
            $display("FAIL rotation_grant%0d: got valid=%b idx=%0d, want 1/%0d",
                     i, gv4, idx4, exp_seq[i]);
         end
         done4 = 1'b1;
         tick();
         done4 = 1'b0;
         n_tests++;
         if (gv4 !== 1'b0 || to4 !== 1'b0) begin
            n_fail++;
            $display("FAIL rotation_release%0d: got valid=%b to=%b, want 0/0", i, gv4, to4);
         end
      end
   endtask

   task automatic test_skip_wrap;
      do_reset();
      req4 = 4'b0100;
      tick();
      n_tests++;
      if (gv4 !== 1'b1 || idx4 !== 2'd2) begin
         n_fail++;
         $display("FAIL skip_first: got valid=%b idx=%0d, want 1/2", gv4, idx4);
      end
      done4 = 1'b1;
      req4  = 4'b0000;
      tick();
      done4 = 1'b0;
      tick();
      n_tests++;
      if (gv4 !== 1'b0 || idx4 !== 2'd2) begin
         n_fail++;
         $display("FAIL idle_hold_idx: got valid=%b idx=%0d, want 0/2", gv4, idx4);
      end
      req4 = 4'b0101;
      tick();
      n_tests++;
      if (gv4 !== 1'b1 || idx4 !== 2'd0) begin
         n_fail++;
         $display("FAIL wrap_to_0: got valid=%b idx=%0d, want 1/0", gv4, idx4);
      end
      done4 = 1'b1;
      tick();
      done4 = 1'b0;
      tick();
      n_tests++;
      if (gv4 !== 1'b1 || idx4 !== 2'd2) begin
         n_fail++;
         $display("FAIL skip_to_2: got valid=%b idx=%0d, want 1/2", gv4, idx4);
      end
   endtask

   task automatic test_withdraw;
      do_reset();
      req4 = 4'b0010;
      tick();
      req4 = 4'b1111;
      tick();
      req4 = 4'b1011;
      n_tests++;
      if (gv4 !== 1'b1 || idx4 !== 2'd1) begin
         n_fail++;
         $display("FAIL withdraw_hold: got valid=%b idx=%0d, want 1/1", gv4, idx4);
      end
      tick();
      req4 = 4'b1101;
      n_tests++;
      if (gv4 !== 1'b1 || idx4 !== 2'd1) begin
         n_fail++;
         $display("FAIL withdraw_other_bits: got valid=%b idx=%0d, want 1/1", gv4, idx4);
      end
      tick();
      n_tests++;
      if (gv4 !== 1'b0 || to4 !== 1'b0 || idx4 !== 2'd1) begin
         n_fail++;
         $display("FAIL withdraw_release: got valid=%b to=%b idx=%0d, want 0/0/1",
                  gv4, to4, idx4);
      end
      tick();
      n_tests++;
      if (gv4 !== 1'b1 || idx4 !== 2'd2) begin
         n_fail++;
         $display("FAIL withdraw_next: got valid=%b idx=%0d, want 1/2", gv4, idx4);
      end
   endtask

   task automatic test_timeout;
      int hi;
      int to_early;
      do_reset();
      req4 = 4'b0010;
      tick();
      hi       = 0;
      to_early = 0;
      while (gv4 === 1'b1 && hi < 10) begin
         hi++;
         if (to4 !== 1'b0) to_early++;
         tick();
      end
      n_tests++;
      if (hi != 4 || to_early != 0) begin
         n_fail++;
         $display("FAIL timeout_len: got %0d high cycles (%0d early pulses), want 4 (0)",
                  hi, to_early);
      end
      n_tests++;
      if (to4 !== 1'b1 || gv4 !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_pulse: got to=%b valid=%b, want 1/0", to4, gv4);
      end
      tick();
      n_tests++;
      if (to4 !== 1'b0 || gv4 !== 1'b1 || idx4 !== 2'd1) begin
         n_fail++;
         $display("FAIL timeout_clear: got to=%b valid=%b idx=%0d, want 0/1/1",
                  to4, gv4, idx4);
      end
   endtask

   task automatic test_done_at_timeout;
      do_reset();
      req4 = 4'b0010;
      tick();
      tick();
      tick();
      tick();
      done4 = 1'b1;
      tick();
      done4 = 1'b0;
      n_tests++;
      if (gv4 !== 1'b0 || to4 !== 1'b0) begin
         n_fail++;
         $display("FAIL done_at_timeout: got valid=%b to=%b, want 0/0", gv4, to4);
      end
      tick();
      tick();
      tick();
      tick();
      req4 = 4'b0000;
      tick();
      n_tests++;
      if (gv4 !== 1'b0 || to4 !== 1'b0) begin
         n_fail++;
         $display("FAIL withdraw_at_timeout: got valid=%b to=%b, want 0/0", gv4, to4);
      end
   endtask

   task automatic test_reset_mid_grant;
      do_reset();
      req4 = 4'b1111;
      tick();
      done4 = 1'b1;
      tick();
      done4 = 1'b0;
      tick();
      n_tests++;
      if (gv4 !== 1'b1 || idx4 !== 2'd1) begin
         n_fail++;
         $display("FAIL midrst_setup: got valid=%b idx=%0d, want 1/1", gv4, idx4);
      end
      rst   = 1'b0;
      done4 = 1'b1;
      tick();
      n_tests++;
      if (gv4 !== 1'b0 || idx4 !== 2'd0 || to4 !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_clear: got valid=%b idx=%0d to=%b, want 0/0/0", gv4, idx4, to4);
      end
      rst   = 1'b1;
      done4 = 1'b0;
      tick();
      n_tests++;
      if (gv4 !== 1'b1 || idx4 !== 2'd0) begin
         n_fail++;
         $display("FAIL midrst_priority: got valid=%b idx=%0d, want 1/0", gv4, idx4);
      end
   endtask

   task automatic test_no_timeout;
      int hi;
      do_reset();
      req0 = 4'b0001;
      tick();
      hi = 0;
      for (int i = 0; i < 100; i++) begin
         if (gv0 === 1'b1 && to0 === 1'b0) hi++;
         tick();
      end
      n_tests++;
      if (hi != 100 || idx0 !== 2'd0) begin
         n_fail++;
         $display("FAIL no_timeout_hold: got %0d high cycles idx=%0d, want 100/0", hi, idx0);
      end
      done0 = 1'b1;
      tick();
      done0 = 1'b0;
      n_tests++;
      if (gv0 !== 1'b0 || to0 !== 1'b0) begin
         n_fail++;
         $display("FAIL no_timeout_done: got valid=%b to=%b, want 0/0", gv0, to0);
      end
   endtask

   task automatic test_timeout16;
      int hi;
      do_reset();
      req16 = 4'b1000;
      tick();
      hi = 0;
      while (gv16 === 1'b1 && hi < 40) begin
         hi++;
         tick();
      end
      n_tests++;
      if (hi != 16 || to16 !== 1'b1 || idx16 !== 2'd3) begin
         n_fail++;
         $display("FAIL timeout16: got %0d high cycles to=%b idx=%0d, want 16/1/3",
                  hi, to16, idx16);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b0;
      req4    = 4'b0000;
      req0    = 4'b0000;
      req16   = 4'b0000;
      done4   = 1'b0;
      done0   = 1'b0;
      done16  = 1'b0;
      test_reset();
      test_rotation();
      test_skip_wrap();
      test_withdraw();
      test_timeout();
      test_done_at_timeout();
      test_reset_mid_grant();
      test_no_timeout();
      test_timeout16();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
